// File: rtl/gfx_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : gfx_mem_arb
// Brief  : Round-robin share of one L2 port among graphics cache memory ports.
// Rev    : 1.0
// ============================================================================
module gfx_mem_arb #(
    parameter  int NUM_INPUTS    = 3,
    parameter  int ADDR_WIDTH    = 26,
    parameter  int DATA_WIDTH    = 512,
    parameter  int IN_TAG_WIDTH  = 8,
    parameter  int MAX_PENDING   = 16,
    localparam int SEL_BITS      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int OUT_TAG_WIDTH = IN_TAG_WIDTH + SEL_BITS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_INPUTS-1:0]                in_req_valid,
    input  logic [NUM_INPUTS-1:0]                in_req_rw,
    input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]     in_req_addr,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]     in_req_data,
    input  logic [NUM_INPUTS*DATA_WIDTH/8-1:0]   in_req_byteen,
    input  logic [NUM_INPUTS*IN_TAG_WIDTH-1:0]   in_req_tag,
    output logic [NUM_INPUTS-1:0]                in_req_ready,
    output logic [NUM_INPUTS-1:0]                in_rsp_valid,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0]     in_rsp_data,
    output logic [NUM_INPUTS*IN_TAG_WIDTH-1:0]   in_rsp_tag,
    input  logic [NUM_INPUTS-1:0]                in_rsp_ready,
    output logic                                 out_req_valid,
    output logic                                 out_req_rw,
    output logic [ADDR_WIDTH-1:0]                out_req_addr,
    output logic [DATA_WIDTH-1:0]                out_req_data,
    output logic [DATA_WIDTH/8-1:0]              out_req_byteen,
    output logic [OUT_TAG_WIDTH-1:0]             out_req_tag,
    input  logic                                 out_req_ready,
    input  logic                                 out_rsp_valid,
    input  logic [DATA_WIDTH-1:0]                out_rsp_data,
    input  logic [OUT_TAG_WIDTH-1:0]             out_rsp_tag,
    output logic                                 out_rsp_ready
);

    localparam int BE_WIDTH    = DATA_WIDTH / 8;
    localparam int CNT_WIDTH   = $clog2(MAX_PENDING) + 1;
    localparam int ENTRY_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH + BE_WIDTH + OUT_TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(MAX_PENDING);
    localparam logic [SEL_BITS-1:0]  LAST_IDX   = SEL_BITS'(NUM_INPUTS - 1);

    logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] credit;
    logic [NUM_INPUTS-1:0]  eligible;
    logic [NUM_INPUTS-1:0]  grant;
    logic [NUM_INPUTS-1:0]  credit_inc;
    logic [NUM_INPUTS-1:0]  credit_dec;
    logic [SEL_BITS-1:0]    rr_ptr;
    logic [SEL_BITS-1:0]    grant_idx;
    logic                   grant_any;
    logic                   accept;
    int                     arb_dist;
    int                     arb_best;

    logic [ENTRY_WIDTH-1:0] fifo_mem [0:1];
    logic [ENTRY_WIDTH-1:0] push_entry;
    logic                   fifo_wr;
    logic                   fifo_rd;
    logic [1:0]             fifo_count;
    logic                   fifo_full;
    logic                   fifo_push;
    logic                   fifo_pop;

    logic                    rsp_valid;
    logic [SEL_BITS-1:0]     rsp_sel;
    logic [IN_TAG_WIDTH-1:0] rsp_tag;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    rsp_drain;
    logic                    rsp_load;
    logic                    rsp_sel_ok;
    logic [SEL_BITS-1:0]     rsp_sel_in;

    // Lowest rotational distance from the pointer wins among eligible inputs.
    always_comb begin
        eligible  = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        arb_best  = NUM_INPUTS;
        arb_dist  = 0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            eligible[i] = in_req_valid[i] && (in_req_rw[i] || (credit[i] < CREDIT_MAX));
            arb_dist = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + NUM_INPUTS - int'(rr_ptr));
            if (eligible[i] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                grant_idx = SEL_BITS'(i);
                grant_any = 1'b1;
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            grant[i] = grant_any && (grant_idx == SEL_BITS'(i));
        end
    end

    assign fifo_full    = (fifo_count == 2'd2);
    assign accept       = grant_any && !fifo_full && reset;
    assign in_req_ready = accept ? grant : '0;
    assign fifo_push    = accept;
    assign fifo_pop     = out_req_valid && out_req_ready;

    always_comb begin
        push_entry = '0;
        credit_inc = '0;
        credit_dec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant[i]) begin
                push_entry = {in_req_rw[i],
                              in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                              in_req_data[i*DATA_WIDTH +: DATA_WIDTH],
                              in_req_byteen[i*BE_WIDTH +: BE_WIDTH],
                              in_req_tag[i*IN_TAG_WIDTH +: IN_TAG_WIDTH],
                              SEL_BITS'(i)};
            end
            credit_inc[i] = accept && grant[i] && !in_req_rw[i];
            credit_dec[i] = in_rsp_valid[i] && in_rsp_ready[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            fifo_wr    <= 1'b0;
            fifo_rd    <= 1'b0;
            fifo_count <= '0;
            credit     <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
            if (fifo_push) begin
                fifo_wr <= ~fifo_wr;
            end
            if (fifo_pop) begin
                fifo_rd <= ~fifo_rd;
            end
            fifo_count <= fifo_count + 2'(fifo_push) - 2'(fifo_pop);
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (credit_inc[i] && !credit_dec[i] && (credit[i] != CREDIT_MAX)) begin
                    credit[i] <= credit[i] + 1'b1;
                end else if (credit_dec[i] && !credit_inc[i] && (credit[i] != '0)) begin
                    credit[i] <= credit[i] - 1'b1;
                end
            end
        end
    end

    // Skid storage is data-only; occupancy lives in fifo_count.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr] <= push_entry;
        end
    end

    assign out_req_valid = (fifo_count != 2'd0);
    assign {out_req_rw, out_req_addr, out_req_data, out_req_byteen, out_req_tag} = fifo_mem[fifo_rd];

    assign rsp_sel_in = out_rsp_tag[SEL_BITS-1:0];
    assign rsp_sel_ok = (int'(rsp_sel_in) < NUM_INPUTS);

    always_comb begin
        rsp_drain = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (rsp_sel == SEL_BITS'(i)) begin
                rsp_drain = in_rsp_ready[i];
            end
        end
    end

    assign out_rsp_ready = reset && (!rsp_valid || rsp_drain);
    assign rsp_load      = out_rsp_valid && out_rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid <= rsp_sel_ok;
        end else if (rsp_valid && rsp_drain) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_load) begin
            rsp_sel  <= rsp_sel_in;
            rsp_tag  <= out_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS];
            rsp_data <= out_rsp_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_rsp_valid[i] = rsp_valid && (rsp_sel == SEL_BITS'(i));
        end
    end

    assign in_rsp_data = {NUM_INPUTS{rsp_data}};
    assign in_rsp_tag  = {NUM_INPUTS{rsp_tag}};

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(rsp_load && !rsp_sel_ok))
                else $error("gfx_mem_arb: response tag selects a nonexistent input");
            for (int i = 0; i < NUM_INPUTS; i++) begin
                assert (!(credit_dec[i] && !credit_inc[i] && (credit[i] == '0)))
                    else $error("gfx_mem_arb: credit underflow on input %0d", i);
                assert (!(credit_inc[i] && !credit_dec[i] && (credit[i] == CREDIT_MAX)))
                    else $error("gfx_mem_arb: credit overflow on input %0d", i);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/gfx_mem_arb.md
Name: gfx_mem_arb

Overview:
Shares one L2 memory port among the graphics cache memory ports (rcache, tcache, ocache) inside a cluster.
- Round-robin arbitration over requests; the input index is appended to the tag LSBs.
- Responses are routed back by those tag LSBs.
- Per-input outstanding-read credit counters bound the number of reads each cache has in flight.
- Sits between the graphics cache clusters and the cluster L2 request port.

Parameters:
NUM_INPUTS, 3, number of requesting cache memory ports (1..8)
ADDR_WIDTH, 26, line address width
DATA_WIDTH, 512, line data width in bits
IN_TAG_WIDTH, 8, per-input tag width
MAX_PENDING, 16, max outstanding reads per input (power of 2, 2..64)
SEL_BITS, derived: clog2(NUM_INPUTS), minimum 1
OUT_TAG_WIDTH, derived: IN_TAG_WIDTH+SEL_BITS

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_req_valid  in  NUM_INPUTS  per-input request valid
in_req_rw  in  NUM_INPUTS  1=write, 0=read
in_req_addr  in  NUM_INPUTS*ADDR_WIDTH  request line address
in_req_data  in  NUM_INPUTS*DATA_WIDTH  write data
in_req_byteen  in  NUM_INPUTS*DATA_WIDTH/8  write byte enables
in_req_tag  in  NUM_INPUTS*IN_TAG_WIDTH  request tag
in_req_ready  out  NUM_INPUTS  request accepted
in_rsp_valid  out  NUM_INPUTS  response valid
in_rsp_data  out  NUM_INPUTS*DATA_WIDTH  response data (shared bus; qualify with in_rsp_valid)
in_rsp_tag  out  NUM_INPUTS*IN_TAG_WIDTH  response tag
in_rsp_ready  in  NUM_INPUTS  response accepted
out_req_valid / out_req_rw / out_req_addr / out_req_data / out_req_byteen  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  L2 request
out_req_tag  out  OUT_TAG_WIDTH  {in_tag, sel}; sel occupies the LSBs
out_req_ready  in  1  L2 accepts request
out_rsp_valid  in  1  L2 response valid
out_rsp_data  in  DATA_WIDTH  response data
out_rsp_tag  in  OUT_TAG_WIDTH  response tag
out_rsp_ready  out  1  response accepted

Behaviour:
- Reset (reset=0, async assert, sync deassert):
  - all valids=0, all credit counters=0, RR pointer=0, output registers empty.
  - in_req_ready=0 and out_rsp_ready=0 while in reset.
- Eligibility: input i is eligible when in_req_valid[i] && (in_req_rw[i] || credit[i] < MAX_PENDING).
  - Writes never consume credit; L2 returns no write response.
- Arbitration: round-robin over eligible inputs, starting at the RR pointer.
  - On acceptance, pointer <= granted index + 1, wrapping at NUM_INPUTS.
- Request stage: a 2-entry skid buffer.
  - Request latency is 1 cycle from in_req handshake to out_req_valid.
  - in_req_ready[i] = grant[i] && buffer not full.
  - Full throughput: one request per cycle while out_req_ready stays 1.
  - out_req_* are held stable while out_req_valid && !out_req_ready.
- Credits: credit[i] increments on an accepted read and decrements on an in_rsp handshake for input i.
  - Simultaneous increment and decrement: the count is unchanged.
  - A decrement at 0 or an increment at MAX_PENDING is an assertion error; the counter saturates.
- Response stage: sel = out_rsp_tag[SEL_BITS-1:0]; registered, latency 1 cycle.
  - in_rsp_valid[sel]=1 and in_rsp_tag = out_rsp_tag[OUT_TAG_WIDTH-1:SEL_BITS].
  - The single response register is one-hot across inputs.
  - out_rsp_ready = !rsp_reg_valid || in_rsp_ready[held sel], so a response can drain and a new one load in the same cycle.
  - sel >= NUM_INPUTS is an assertion error; the response is dropped.
- NUM_INPUTS=1: arbitration is bypassed; sel bit is still appended as 0.
- Reset mid-transfer: all in-flight state is discarded. Callers reset the caches together with this block.

Test Plan:
- Single read, input 1: addr=0x100, tag=0x5A, out_req_ready=1 -> next cycle out_req_valid=1, out_req_tag=0x5A<<2|1, credit[1]=1. Return a response with that tag -> in_rsp_valid[1]=1 with in_rsp_tag=0x5A one cycle later; credit[1]=0.
- All 3 inputs valid continuously, out_req_ready=1 -> grant order 0,1,2,0,1,2; one request per cycle.
- out_req_ready=0 for 5 cycles -> out_req fields held stable; at most 2 requests accepted; 3rd in_req_ready=0 until ready returns.
- Input 0 issues 16 reads with no responses -> 17th read blocked (in_req_ready[0]=0) while input 2 writes still flow. One response to input 0 -> 17th read accepted next arbitration.
- Response to input 2 with in_rsp_ready[2]=0 for 3 cycles -> out_rsp_ready=0 and data/tag held. A same-cycle drain and new load -> no bubble, credit correct.
- Assert reset=0 asynchronously with 2 buffered requests and 1 pending response -> all valids drop immediately; after release, credits=0 and arbitration starts at input 0.
